// File: rtl/tsetlin_feedback_if.sv
// Sample/decision bundle between the training driver and tsetlin_feedback.
// The master side presents samples and the automaton's action; the slave
// side (the feedback block) returns the reward/penalty decision.
interface tsetlin_feedback_if;
  logic        in_valid;
  logic        in_ready;
  logic        literal;
  logic        clause_out;
  logic        y;
  logic        alpha;
  logic        x;
  logic        x_valid;
  logic [15:0] pen_count;

  modport master (
    output in_valid, literal, clause_out, y, alpha,
    input  in_ready, x, x_valid, pen_count
  );

  modport slave (
    input  in_valid, literal, clause_out, y, alpha,
    output in_ready, x, x_valid, pen_count
  );
endinterface

// File: rtl/tsetlin_feedback.sv
// Tsetlin Machine Type I / Type II feedback generator.
// Turns each accepted training sample into one reward (x=1) or penalty (x=0)
// bit for the downstream automaton. Stochastic gating comes from a 16-bit
// Galois LFSR; a "rare" event has probability 1/2^S_LOG2.
module tsetlin_feedback #(
  parameter int          S_LOG2   = 2,
  parameter int          BOOST_TP = 0,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          WARMUP   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tsetlin_feedback_if.slave fb
);

  // An all-zero seed would lock the LFSR, so fall back to the default seed.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'd0) ? 16'hACE1 : SEED;
  // Low S_LOG2 bits select the rare event; S_LOG2=0 gives an empty mask,
  // which makes every cycle rare.
  localparam logic [15:0] RARE_MASK = 16'((32'd1 << S_LOG2) - 32'd1);
  localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);
  // Taps x^16+x^14+x^13+x^11+1 for a right-shifting Galois register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_RESET,
    S_WARM,
    S_RUN
  } state_t;

  state_t      state;
  logic [7:0]  warm_cnt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        rare;
  logic        freq;
  logic        decision;

  // Next LFSR value: shift right and fold the taps in when a one falls out.
  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) begin
      lfsr_next = (lfsr >> 1) ^ LFSR_TAPS;
    end
  end

  // Free-running LFSR; held at the seed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  // Feedback decision for the sample on the inputs, using the pre-edge LFSR.
  always_comb begin
    rare     = ((lfsr & RARE_MASK) == 16'd0);
    freq     = (BOOST_TP != 0) || !rare;
    decision = 1'b1;
    if (fb.y) begin
      if (fb.clause_out && fb.literal) begin
        if (freq) begin
          decision = fb.alpha;
        end
      end else begin
        if (rare) begin
          decision = !fb.alpha;
        end
      end
    end else begin
      if (fb.clause_out && !fb.literal && !fb.alpha) begin
        decision = 1'b0;
      end
    end
  end

  // Warm-up / run sequencing with registered decision and penalty counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_WARM;
      warm_cnt     <= 8'd0;
      fb.in_ready  <= 1'b0;
      fb.x         <= 1'b1;
      fb.x_valid   <= 1'b0;
      fb.pen_count <= 16'd0;
    end else begin
      fb.x       <= 1'b1;
      fb.x_valid <= 1'b0;
      case (state)
        S_WARM: begin
          if (warm_cnt == WARM_LAST) begin
            state       <= S_RUN;
            fb.in_ready <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (fb.in_valid) begin
            fb.x       <= decision;
            fb.x_valid <= 1'b1;
            if (!decision && (fb.pen_count != 16'hFFFF)) begin
              fb.pen_count <= fb.pen_count + 16'd1;
            end
          end
        end
        default: begin
          state       <= S_WARM;
          warm_cnt    <= 8'd0;
          fb.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tsetlin_feedback.sv
// Directed bench for tsetlin_feedback: reset/warm-up, deterministic Type I,
// Type II with back-to-back samples, stochastic penalty rate against an LFSR
// reference, counter saturation and a mid-stream reset.
module tb_tsetlin_feedback;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          WARM = 16;

  typedef struct {
    logic y;
    logic c;
    logic l;
    logic a;
    logic x;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad   = 0;
  logic [15:0] ref_lfsr;

  tsetlin_feedback_if ifa ();
  tsetlin_feedback_if ifb ();

  tsetlin_feedback #(.S_LOG2(0), .BOOST_TP(1), .SEED(SEED), .WARMUP(WARM)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .fb    (ifa)
  );

  tsetlin_feedback #(.S_LOG2(2), .BOOST_TP(0), .SEED(SEED), .WARMUP(WARM)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .fb    (ifb)
  );

  always #5 clk = ~clk;

  // Reference Galois LFSR (x^16+x^14+x^13+x^11+1), reset to the seed.
  always @(posedge clk) begin
    if (!rst_n) ref_lfsr <= SEED;
    else        ref_lfsr <= ref_lfsr[0] ? ((ref_lfsr >> 1) ^ 16'hB400) : (ref_lfsr >> 1);
  end

  task automatic drive_a(input logic v, input logic y, input logic c, input logic l, input logic a);
    ifa.in_valid = v; ifa.y = y; ifa.clause_out = c; ifa.literal = l; ifa.alpha = a;
  endtask

  task automatic drive_b(input logic v, input logic y, input logic c, input logic l, input logic a);
    ifb.in_valid = v; ifb.y = y; ifb.clause_out = c; ifb.literal = l; ifb.alpha = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    total++; if (ifa.x !== 1'b1) begin bad++; $display("[TB] FAIL reset_x_a: got %b expected 1", ifa.x); end
    total++; if (ifa.x_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_xv_a: got %b expected 0", ifa.x_valid); end
    total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy_a: got %b expected 0", ifa.in_ready); end
    total++; if (ifa.pen_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_pen_a: got %0h expected 0", ifa.pen_count); end
    total++; if (ifb.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy_b: got %b expected 0", ifb.in_ready); end
    total++; if (ifb.pen_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_pen_b: got %0h expected 0", ifb.pen_count); end
    rst_n = 1'b1;
    for (int i = 1; i <= WARM; i++) begin
      drive_a(1, 0, 1, 0, 0);
      drive_b(1, 1, 0, 0, 1);
      @(negedge clk);
      total++;
      if (ifa.in_ready !== (i == WARM)) begin
        bad++; $display("[TB] FAIL warm_rdy cycle %0d: got %b expected %b", i, ifa.in_ready, (i == WARM));
      end
      total++;
      if (ifa.x !== 1'b1 || ifa.x_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL warm_drop_a cycle %0d: got x=%b xv=%b expected x=1 xv=0", i, ifa.x, ifa.x_valid);
      end
      total++;
      if (ifb.x !== 1'b1 || ifb.x_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL warm_drop_b cycle %0d: got x=%b xv=%b expected x=1 xv=0", i, ifb.x, ifb.x_valid);
      end
    end
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (ifa.pen_count !== 16'd0) begin bad++; $display("[TB] FAIL warm_pen_a: got %0h expected 0", ifa.pen_count); end
    total++; if (ifb.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL warm_rdy_b: got %b expected 1", ifb.in_ready); end
  endtask

  task automatic test_type1_det();
    vec_t v[4];
    v[0] = '{y: 1'b1, c: 1'b1, l: 1'b1, a: 1'b0, x: 1'b0};
    v[1] = '{y: 1'b1, c: 1'b1, l: 1'b1, a: 1'b1, x: 1'b1};
    v[2] = '{y: 1'b1, c: 1'b0, l: 1'b0, a: 1'b1, x: 1'b0};
    v[3] = '{y: 1'b1, c: 1'b0, l: 1'b0, a: 1'b0, x: 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive_a(1, v[i].y, v[i].c, v[i].l, v[i].a);
      @(negedge clk);
      total++;
      if (ifa.x !== v[i].x || ifa.x_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL type1_vec%0d: got x=%b xv=%b expected x=%b xv=1", i, ifa.x, ifa.x_valid, v[i].x);
      end
    end
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (ifa.x !== 1'b1 || ifa.x_valid !== 1'b0) begin bad++; $display("[TB] FAIL type1_idle: got x=%b xv=%b expected x=1 xv=0", ifa.x, ifa.x_valid); end
    total++; if (ifa.pen_count !== 16'd2) begin bad++; $display("[TB] FAIL type1_pen: got %0d expected 2", ifa.pen_count); end
  endtask

  task automatic test_type2_back_to_back();
    vec_t v[4];
    v[0] = '{y: 1'b0, c: 1'b1, l: 1'b0, a: 1'b0, x: 1'b0};
    v[1] = '{y: 1'b0, c: 1'b1, l: 1'b0, a: 1'b1, x: 1'b1};
    v[2] = '{y: 1'b0, c: 1'b1, l: 1'b1, a: 1'b0, x: 1'b1};
    v[3] = '{y: 1'b0, c: 1'b0, l: 1'b0, a: 1'b0, x: 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive_a(1, v[i].y, v[i].c, v[i].l, v[i].a);
      @(negedge clk);
      total++;
      if (ifa.x !== v[i].x || ifa.x_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL type2_vec%0d: got x=%b xv=%b expected x=%b xv=1", i, ifa.x, ifa.x_valid, v[i].x);
      end
    end
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (ifa.pen_count !== 16'd3) begin bad++; $display("[TB] FAIL type2_pen: got %0d expected 3", ifa.pen_count); end
  endtask

  task automatic test_stochastic();
    int   exp_pen = 0;
    int   xbad    = 0;
    logic exp_x;
    total++; if (ifb.pen_count !== 16'd0) begin bad++; $display("[TB] FAIL stoch_base: got %0d expected 0", ifb.pen_count); end
    for (int i = 0; i < 4096; i++) begin
      drive_b(1, 1, 0, 0, 1);
      exp_x = (ref_lfsr[1:0] != 2'b00);
      if (!exp_x) exp_pen++;
      @(negedge clk);
      if (ifb.x !== exp_x || ifb.x_valid !== 1'b1) xbad++;
    end
    drive_b(0, 0, 0, 0, 0);
    total++; if (xbad !== 0) begin bad++; $display("[TB] FAIL stoch_x_seq: got %0d wrong decisions expected 0", xbad); end
    @(negedge clk);
    total++; if (ifb.pen_count !== 16'(exp_pen)) begin bad++; $display("[TB] FAIL stoch_exact: got %0d expected %0d", ifb.pen_count, exp_pen); end
    total++;
    if (ifb.pen_count < 16'd960 || ifb.pen_count > 16'd1088) begin
      bad++; $display("[TB] FAIL stoch_rate: got %0d expected 960..1088", ifb.pen_count);
    end
  endtask

  task automatic test_saturation_and_reset();
    int xbad = 0;
    for (int i = 0; i < 70000; i++) begin
      drive_a(1, 0, 1, 0, 0);
      @(negedge clk);
      if (ifa.x !== 1'b0 || ifa.x_valid !== 1'b1) xbad++;
    end
    total++; if (xbad !== 0) begin bad++; $display("[TB] FAIL sat_x_seq: got %0d wrong decisions expected 0", xbad); end
    total++; if (ifa.pen_count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_pen: got %0h expected ffff", ifa.pen_count); end
    @(negedge clk);
    total++; if (ifa.x !== 1'b0) begin bad++; $display("[TB] FAIL sat_x_hold: got %b expected 0", ifa.x); end
    total++; if (ifa.pen_count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_pen_hold: got %0h expected ffff", ifa.pen_count); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (ifa.pen_count !== 16'd0) begin bad++; $display("[TB] FAIL midrst_pen: got %0h expected 0", ifa.pen_count); end
    total++; if (ifa.x !== 1'b1 || ifa.x_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_x: got x=%b xv=%b expected x=1 xv=0", ifa.x, ifa.x_valid); end
    total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_rdy: got %b expected 0", ifa.in_ready); end
    total++; if (ifb.pen_count !== 16'd0) begin bad++; $display("[TB] FAIL midrst_pen_b: got %0h expected 0", ifb.pen_count); end
    rst_n = 1'b1;
    repeat (WARM - 1) @(negedge clk);
    total++; if (ifa.in_ready !== 1'b0 || ifa.x_valid !== 1'b0) begin bad++; $display("[TB] FAIL rewarm_early: got rdy=%b xv=%b expected rdy=0 xv=0", ifa.in_ready, ifa.x_valid); end
    @(negedge clk);
    total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rewarm_rdy: got %b expected 1", ifa.in_ready); end
    @(negedge clk);
    total++; if (ifa.x !== 1'b0 || ifa.x_valid !== 1'b1) begin bad++; $display("[TB] FAIL rewarm_first: got x=%b xv=%b expected x=0 xv=1", ifa.x, ifa.x_valid); end
    total++; if (ifa.pen_count !== 16'd1) begin bad++; $display("[TB] FAIL rewarm_pen: got %0d expected 1", ifa.pen_count); end
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting tsetlin_feedback bench");
    test_reset();
    test_type1_det();
    test_type2_back_to_back();
    test_stochastic();
    test_saturation_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
